// File: rtl/instr_fetch.sv
// Instruction-fetch initiator: owns the PC, the branch-delay-slot sequencing,
// J/JAL target formation and halt detection on a jump to address 0.
module instr_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_instr,
  output logic        active,
  output logic        fetch_error
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DELAY  = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] target_q;
  logic        error_q;

  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic        is_jump;
  logic        consume;

  assign pc_plus4    = pc_q + 32'd4;
  // J (000010) and JAL (000011) differ only in the opcode LSB.
  assign is_jump     = (instr_readdata[31:27] == 5'b00001);
  assign jump_target = {pc_plus4[31:28], instr_readdata[25:0], 2'b00};
  assign consume     = (state_q != HALTED) && !stall;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every branch below reads the pre-edge values of pc_q and target_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      pc_q     <= RESET_VECTOR;
      target_q <= 32'd0;
      error_q  <= 1'b0;
    end else if (consume) begin
      unique case (state_q)
        RUN: begin
          pc_q <= pc_plus4;
          if (is_jump) begin
            target_q <= jump_target;
            state_q  <= DELAY;
          end else if (redirect_valid) begin
            target_q <= redirect_target;
            state_q  <= DELAY;
          end
        end
        DELAY: begin
          // The delay slot is never itself a control transfer; the first target wins.
          if (target_q == 32'd0) begin
            pc_q    <= 32'd0;
            state_q <= HALTED;
          end else if (target_q[1:0] != 2'b00) begin
            pc_q    <= target_q;
            error_q <= 1'b1;
            state_q <= HALTED;
          end else begin
            pc_q    <= target_q;
            state_q <= RUN;
          end
        end
        default: state_q <= HALTED;
      endcase
    end
  end

  assign instr_address = pc_q;
  assign fetch_pc      = pc_q;
  assign fetch_instr   = instr_readdata;
  assign fetch_valid   = (state_q != HALTED);
  assign active        = (state_q != HALTED);
  assign fetch_error   = error_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized traffic
// compared against a behavioural model built on a pending-target queue.
module tb_instr_fetch;

  localparam logic [31:0] RV = 32'hBFC00000;
  localparam logic [31:0] NOP = 32'h00000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic        active;
  logic        fetch_error;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a non-empty pending queue means the next consumed
  // instruction is a delay slot.
  logic [31:0] m_pc;
  logic [31:0] m_pending[$];
  bit          m_halted;
  bit          m_err;

  instr_fetch #(.RESET_VECTOR(RV)) dut (
    .clk            (clk),
    .reset          (reset),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .fetch_valid    (fetch_valid),
    .fetch_pc       (fetch_pc),
    .fetch_instr    (fetch_instr),
    .active         (active),
    .fetch_error    (fetch_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] j_instr(input logic link, input logic [25:0] j_addr);
    return {5'b00001, link, j_addr};
  endfunction

  function automatic logic [31:0] plain_instr();
    logic [31:0] w;
    w = $urandom;
    if (w[31:27] == 5'b00001) w[29] = ~w[29];
    return w;
  endfunction

  task automatic model_reset();
    m_pc     = RV;
    m_pending.delete();
    m_halted = 1'b0;
    m_err    = 1'b0;
  endtask

  // Called at a falling edge; leaves the bench at the next falling edge.
  task automatic do_reset();
    reset           = 1'b1;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;
    instr_readdata  = NOP;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_outputs();
    check("instr_address", instr_address, m_pc);
    check("fetch_pc", fetch_pc, m_pc);
    check("fetch_valid", {31'd0, fetch_valid}, {31'd0, !m_halted});
    check("active", {31'd0, active}, {31'd0, !m_halted});
    check("fetch_error", {31'd0, fetch_error}, {31'd0, m_err});
  endtask

  task automatic step(input logic st, input logic rv, input logic [31:0] rt,
                      input logic [31:0] ins);
    logic [31:0] t;
    logic [31:0] pc4;
    check_outputs();
    stall           = st;
    redirect_valid  = rv;
    redirect_target = rt;
    instr_readdata  = ins;
    #1;
    check("fetch_instr", fetch_instr, ins);
    @(posedge clk);
    if (!m_halted && !st) begin
      pc4 = m_pc + 32'd4;
      if (m_pending.size() == 0) begin
        if (ins[31:26] == 6'b000010 || ins[31:26] == 6'b000011)
          m_pending.push_back({pc4[31:28], ins[25:0], 2'b00});
        else if (rv)
          m_pending.push_back(rt);
        m_pc = pc4;
      end else begin
        t = m_pending.pop_front();
        if (t == 32'd0) begin
          m_halted = 1'b1;
          m_pc     = 32'd0;
        end else if (t % 4 != 0) begin
          m_halted = 1'b1;
          m_err    = 1'b1;
          m_pc     = t;
        end else begin
          m_pc = t;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic nop_step();
    step(1'b0, 1'b0, 32'd0, NOP);
  endtask

  task automatic expect_addr(input string tag, input logic [31:0] exp);
    check(tag, instr_address, exp);
  endtask

  initial begin
    reset           = 1'b1;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;
    instr_readdata  = NOP;
    @(negedge clk);
    do_reset();

    // Reset vector, sequential fetch, then JR r0 halting after the delay slot.
    expect_addr("rst_vec", 32'hBFC00000);
    check("rst_valid", {31'd0, fetch_valid}, 32'd1);
    check("rst_err", {31'd0, fetch_error}, 32'd0);
    nop_step();
    expect_addr("seq1", 32'hBFC00004);
    nop_step();
    expect_addr("seq2", 32'hBFC00008);
    nop_step();
    expect_addr("seq3", 32'hBFC0000C);
    step(1'b0, 1'b1, 32'd0, plain_instr());
    expect_addr("halt_slot", 32'hBFC00010);
    check("halt_slot_valid", {31'd0, fetch_valid}, 32'd1);
    nop_step();
    check("halt_active", {31'd0, active}, 32'd0);
    check("halt_addr", instr_address, 32'd0);
    for (int i = 0; i < 10; i++)
      step(1'($urandom), 1'($urandom), $urandom, j_instr(1'b0, 26'h0001000));
    check("halt_hold_addr", instr_address, 32'd0);
    check("halt_hold_active", {31'd0, active}, 32'd0);

    // Jump across a 256 MB region boundary.
    do_reset();
    step(1'b0, 1'b1, 32'h1FFFFFF8, NOP);
    nop_step();
    expect_addr("pre_region", 32'h1FFFFFF8);
    nop_step();
    expect_addr("region_j", 32'h1FFFFFFC);
    step(1'b0, 1'b0, 32'd0, j_instr(1'b0, 26'h3C03C00));
    expect_addr("region_slot", 32'h20000000);
    nop_step();
    expect_addr("region_tgt", 32'h2F00F000);
    step(1'b0, 1'b0, 32'd0, j_instr(1'b1, 26'h3FFFFFF));
    expect_addr("jal_slot", 32'h2F00F004);
    nop_step();
    expect_addr("jal_tgt", 32'h2FFFFFFC);

    // Stall while the delay slot is presented.
    step(1'b0, 1'b1, 32'h3ABCDEF0, NOP);
    for (int i = 0; i < 3; i++) begin
      expect_addr("stall_slot", 32'h30000000);
      step(1'b1, 1'b0, 32'd0, NOP);
    end
    expect_addr("stall_slot_last", 32'h30000000);
    nop_step();
    expect_addr("stall_tgt", 32'h3ABCDEF0);

    // J wins over a same-cycle redirect; a redirect in the delay slot is ignored.
    step(1'b0, 1'b1, 32'h12345678, j_instr(1'b0, 26'h0001000));
    expect_addr("prec_slot", 32'h3ABCDEF4);
    step(1'b0, 1'b1, 32'h00000000, j_instr(1'b0, 26'h0002000));
    expect_addr("prec_tgt", 32'h30004000);
    check("prec_active", {31'd0, active}, 32'd1);

    // Sequential wrap through 0 is not a halt.
    step(1'b0, 1'b1, 32'hFFFFFFF8, NOP);
    nop_step();
    nop_step();
    expect_addr("wrap_pre", 32'hFFFFFFFC);
    nop_step();
    expect_addr("wrap_zero", 32'h00000000);
    check("wrap_active", {31'd0, active}, 32'd1);

    // Misaligned redirect sets the sticky error and halts.
    step(1'b0, 1'b1, 32'h00400002, NOP);
    nop_step();
    check("mis_err", {31'd0, fetch_error}, 32'd1);
    check("mis_active", {31'd0, active}, 32'd0);
    expect_addr("mis_pc", 32'h00400002);
    nop_step();
    nop_step();
    do_reset();
    check("mis_clr", {31'd0, fetch_error}, 32'd0);
    expect_addr("mis_rst_vec", 32'hBFC00000);

    // Reset during the delay slot discards the pending target.
    step(1'b0, 1'b1, 32'h00001000, NOP);
    expect_addr("rst_dly_slot", 32'hBFC00004);
    do_reset();
    expect_addr("rst_dly_vec", 32'hBFC00000);
    nop_step();
    expect_addr("rst_dly_seq", 32'hBFC00004);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic        st;
      logic        rv;
      logic [31:0] rt;
      logic [31:0] ins;
      st  = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 5) == 0);
      rt  = {$urandom, 2'b00} >> 2 << 2;
      rt  = {rt[31:2], 2'b00};
      case ($urandom_range(0, 19))
        0:       rt = 32'd0;
        1:       rt = rt | 32'($urandom_range(1, 3));
        default: ;
      endcase
      ins = ($urandom_range(0, 7) == 0) ? j_instr(1'($urandom), 26'($urandom))
                                         : plain_instr();
      if (m_halted && $urandom_range(0, 3) == 0) do_reset();
      else if ($urandom_range(0, 150) == 0) do_reset();
      else step(st, rv, rt, ins);
    end
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
